serial_adder_fsm: RTL and testbench



---
 rtl/serial_adder_fsm.sv | 173 +++++++++++++++++
 tb/tb_serial_adder_fsm.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_fsm.sv
// -----------------------------------------------------------------------------
// serial_adder_fsm
//
// Bit-serial ripple adder. A single full-adder cell and a registered carry
// step LSB-first over a WIDTH-bit operand pair. A request is made with start
// and answered with a one-cycle done pulse. An operation takes WIDTH+1 clock
// edges from the edge that accepts start to the cycle in which done is high.
//
// Optional feature (macro SERIAL_ADDER_SUB_EN):
//   When defined, the design adds a 'sub' input. With sub=1 the b operand is
//   captured inverted and the carry register starts at ~cin, so the same
//   datapath computes a - b - cin. In that mode cout reads as ~borrow.
//   When the macro is undefined the design adds only. Timing is identical in
//   both builds.
//
// Parameters:
//   WIDTH  operand/result width in bits, 1..32 (default 8)
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset
//   start  in   request; sampled only in IDLE or DONE
//   sub    in   (SERIAL_ADDER_SUB_EN only) 1 = subtract; captured with operands
//   a      in   WIDTH  augend/minuend; captured on accepted start
//   b      in   WIDTH  addend/subtrahend; captured on accepted start
//   cin    in   carry in (borrow in when subtracting); captured on accept
//   busy   out  high while bits are being processed
//   done   out  one-cycle pulse; sum/cout valid
//   sum    out  WIDTH  result; held until the next accepted start
//   cout   out  carry out; held with sum
//
// Handshake: start is a request that is accepted on any rising edge where the
// FSM is in IDLE or DONE and rst_n is high. While busy, start is ignored and
// the operands are not re-sampled. done is high for exactly one cycle per
// completed operation. sum and cout are stable from the done cycle until the
// next accepted start. While busy, sum is shifted in place and carries no
// meaning.
// -----------------------------------------------------------------------------
module serial_adder_fsm #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // The counter is one bit wider than strictly needed. It therefore reaches
  // WIDTH on the final edge without wrapping.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sr, a_sr_nx;
  logic [WIDTH-1:0] b_sr, b_sr_nx;
  logic [WIDTH-1:0] sum_nx;
  logic             carry, carry_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             busy_nx, done_nx, cout_nx;

  // Operand values as they enter the datapath. When subtracting, b is
  // inverted and the carry starts at ~cin. The result is then
  // a + ~b + ~cin = a - b - cin (mod 2^WIDTH).
  logic [WIDTH-1:0] b_cap;
  logic             carry_cap;

`ifdef SERIAL_ADDER_SUB_EN
  assign b_cap     = sub ? ~b   : b;
  assign carry_cap = sub ? ~cin : cin;
`else
  assign b_cap     = b;
  assign carry_cap = cin;
`endif

  // One full-adder cell on the current LSBs.
  logic s_bit, c_bit;
  assign s_bit = a_sr[0] ^ b_sr[0] ^ carry;
  assign c_bit = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);

  // Next-state and datapath logic.
  always_comb begin
    state_nx = state;
    a_sr_nx  = a_sr;
    b_sr_nx  = b_sr;
    sum_nx   = sum;
    carry_nx = carry;
    cnt_nx   = cnt;
    busy_nx  = busy;
    done_nx  = 1'b0;
    cout_nx  = cout;

    case (state)
      // IDLE and DONE accept a request in the same way. This lets
      // back-to-back operations issue from the done cycle.
      IDLE, DONE: begin
        if (start) begin
          a_sr_nx  = a;
          b_sr_nx  = b_cap;
          carry_nx = carry_cap;
          cnt_nx   = '0;
          busy_nx  = 1'b1;
          state_nx = SHIFT;
        end else begin
          busy_nx  = 1'b0;
          state_nx = IDLE;
        end
      end

      SHIFT: begin
        a_sr_nx  = a_sr >> 1;
        b_sr_nx  = b_sr >> 1;
        // The new bit enters at the MSB. After WIDTH shifts, bit 0 of the
        // result sits at the LSB. This form also works for WIDTH=1.
        sum_nx   = (sum >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
        carry_nx = c_bit;
        cnt_nx   = cnt + 1'b1;
        if (cnt == LAST_BIT) begin
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
          cout_nx  = c_bit;
          state_nx = DONE;
        end
      end

      default: begin
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset clears everything, which aborts any
  // operation in flight without a done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      sum   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      cout  <= 1'b0;
    end else begin
      state <= state_nx;
      a_sr  <= a_sr_nx;
      b_sr  <= b_sr_nx;
      sum   <= sum_nx;
      carry <= carry_nx;
      cnt   <= cnt_nx;
      busy  <= busy_nx;
      done  <= done_nx;
      cout  <= cout_nx;
    end
  end

endmodule

// File: tb/tb_serial_adder_fsm.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_fsm
//
// Testbench for serial_adder_fsm. It instantiates a WIDTH=8 and a WIDTH=1
// instance, drives them with a directed vector table, runs hand-written
// sequences for reset, abort and back-to-back cases, and then runs a
// random sweep. With SERIAL_ADDER_SUB_EN defined, it also exercises the
// subtract mode.
// -----------------------------------------------------------------------------
module tb_serial_adder_fsm;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;
`ifdef SERIAL_ADDER_SUB_EN
  logic       sub8, sub1;
`endif

  serial_adder_fsm #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub8),
`endif
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  serial_adder_fsm #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub1),
`endif
    .a     (a1),
    .b     (b1),
    .cin   (cin1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1)
  );

  // ---------------- scoreboard state ----------------
  int          tests = 0;
  int          fails = 0;
  logic [32:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- DUT access helpers (sel: 0 = W8, 1 = W1) ----------------
  function automatic logic get_busy(input int sel);
    return (sel != 0) ? busy1 : busy8;
  endfunction
  function automatic logic get_done(input int sel);
    return (sel != 0) ? done1 : done8;
  endfunction
  function automatic logic get_cout(input int sel);
    return (sel != 0) ? cout1 : cout8;
  endfunction
  function automatic logic [31:0] get_sum(input int sel);
    return (sel != 0) ? {31'b0, sum1} : {24'b0, sum8};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input int sel, input logic st, input logic [31:0] av,
                       input logic [31:0] bv, input logic ci, input logic sb);
    if (sel != 0) begin
      start1 = st; a1 = av[0:0]; b1 = bv[0:0]; cin1 = ci;
    end else begin
      start8 = st; a8 = av[7:0]; b8 = bv[7:0]; cin8 = ci;
    end
`ifdef SERIAL_ADDER_SUB_EN
    if (sel != 0) sub1 = sb; else sub8 = sb;
`else
    if (sb) $display("note: sub requested in add-only build");
`endif
  endtask

  // Call this #1 after a rising edge. It issues one operation and waits for
  // done, with a time bound. It checks busy on every cycle and the latency
  // in edges after the accepting edge. On return it is #1 after the edge
  // that follows the done cycle.
  task automatic run_op(input int sel, input logic [31:0] av, input logic [31:0] bv,
                        input logic ci, input logic sb,
                        output logic [31:0] s, output logic c);
    int  lat;
    bit  seen;
    int  w;
    w = (sel != 0) ? 1 : 8;
    drive(sel, 1'b1, av, bv, ci, sb);
    @(posedge clk);  // accepting edge E0
    #1;
    drive(sel, 1'b0, ~av, ~bv, ~ci, ~sb);  // later operand changes must not matter
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat <= 40) begin
      @(negedge clk);
      if (get_done(sel)) begin
        seen = 1'b1;
      end else begin
        check("busy_during_op", get_busy(sel), 1'b1);
        @(posedge clk);
        lat++;
      end
    end
    check("done_seen", seen, 1'b1);
    check("latency_edges", lat, w);
    check("busy_low_at_done", get_busy(sel), 1'b0);
    s = get_sum(sel);
    c = get_cout(sel);
    @(posedge clk);
    #1;
  endtask

  // Bounded wait until the selected DUT is idle (neither busy nor done).
  task automatic wait_idle(input int sel);
    int n;
    n = 0;
    @(negedge clk);
    while ((get_busy(sel) || get_done(sel)) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle_bound", (n < 40), 1'b1);
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] s;
    logic       c;
  } vec_t;

  vec_t vecs[$];

  // ---------------- main test ----------------
  initial begin
    logic [31:0] s;
    logic        c;
    int          k;
    int          last_done;
    int          n_done;
    bit          bad_gap;
    bit          glitch;
    bit          seen;

    rst_n = 1'b0;
    drive(0, 1'b0, 0, 0, 1'b0, 1'b0);
    drive(1, 1'b0, 0, 0, 1'b0, 1'b0);

    vecs.push_back('{"add_35_4a",   8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0});
    vecs.push_back('{"add_ff_01",   8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{"add_ff_00_c", 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{"add_aa_55_c", 8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{"add_12_34_c", 8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0});
    vecs.push_back('{"add_80_80",   8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{"add_00_00",   8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{"add_7f_7f_c", 8'h7F, 8'h7F, 1'b1, 1'b0, 8'hFF, 1'b0});
`ifdef SERIAL_ADDER_SUB_EN
    vecs.push_back('{"sub_10_01",   8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1});
    vecs.push_back('{"sub_00_01",   8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0});
    vecs.push_back('{"sub_05_05_b", 8'h05, 8'h05, 1'b1, 1'b1, 8'hFF, 1'b0});
`endif

    // Reset with start asserted: reset must win.
    start8 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy8", busy8, 1'b0);
    check("rst_done8", done8, 1'b0);
    check("rst_sum8",  sum8,  8'h00);
    check("rst_cout8", cout8, 1'b0);
    check("rst_busy1", busy1, 1'b0);
    check("rst_sum1",  sum1,  1'b0);
    @(posedge clk);
    #1;
    start8 = 1'b0;
    rst_n  = 1'b1;
    @(posedge clk);
    #1;

    // Directed table on the 8-bit instance, with a hold check after done.
    foreach (vecs[i]) begin
      run_op(0, {24'b0, vecs[i].a}, {24'b0, vecs[i].b}, vecs[i].cin, vecs[i].sub, s, c);
      check({vecs[i].name, "_sum"},  s[7:0], vecs[i].s);
      check({vecs[i].name, "_cout"}, c,      vecs[i].c);
      @(negedge clk);
      check({vecs[i].name, "_done_drop"}, done8, 1'b0);
      check({vecs[i].name, "_sum_hold"},  sum8,  vecs[i].s);
      check({vecs[i].name, "_cout_hold"}, cout8, vecs[i].c);
      @(posedge clk);
      #1;
    end

    // Start held high: done every 9 cycles and busy|done never low.
    drive(0, 1'b1, 32'h01, 32'h02, 1'b0, 1'b0);
    last_done = -1;
    n_done    = 0;
    bad_gap   = 1'b0;
    glitch    = 1'b0;
    for (k = 0; k < 30; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (!(busy8 || done8)) glitch = 1'b1;
      if (done8) begin
        check("b2b_sum", sum8, 8'h03);
        check("b2b_cout", cout8, 1'b0);
        if (last_done >= 0 && (k - last_done) != 9) bad_gap = 1'b1;
        last_done = k;
        n_done++;
      end
    end
    check("b2b_done_count", n_done, 3);
    check("b2b_gap_9", bad_gap, 1'b0);
    check("b2b_no_busy_glitch", glitch, 1'b0);
    start8 = 1'b0;
    wait_idle(0);

    // Start pulse during busy with different operands is ignored.
    drive(0, 1'b1, 32'h01, 32'h02, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    drive(0, 1'b1, 32'hF0, 32'hF0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    start8 = 1'b0;
    seen = 1'b0;
    k = 0;
    while (!seen && k < 20) begin
      @(negedge clk);
      if (done8) seen = 1'b1;
      k++;
    end
    check("ignore_start_done", seen, 1'b1);
    check("ignore_start_sum",  sum8,  8'h03);
    check("ignore_start_cout", cout8, 1'b0);
    wait_idle(0);

    // Reset during the 4th shift edge aborts the operation without done.
    drive(0, 1'b1, 32'h35, 32'h4A, 1'b0, 1'b0);
    @(posedge clk);          // E0
    #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);  // E1..E3
    #1;
    rst_n  = 1'b0;
    start8 = 1'b1;
    @(posedge clk);          // E4 with reset
    #1;
    rst_n  = 1'b1;
    start8 = 1'b0;
    @(negedge clk);
    check("abort_busy", busy8, 1'b0);
    check("abort_done", done8, 1'b0);
    check("abort_sum",  sum8,  8'h00);
    check("abort_cout", cout8, 1'b0);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) seen = 1'b1;
    end
    check("abort_no_done", seen, 1'b0);
    @(posedge clk);
    #1;
    run_op(0, 32'h35, 32'h4A, 1'b0, 1'b0, s, c);
    check("after_abort_sum",  s[7:0], 8'h7F);
    check("after_abort_cout", c,      1'b0);

    // Random sweep on both widths.
    for (int sel = 0; sel < 2; sel++) begin
      for (int i = 0; i < 1000; i++) begin
        logic [31:0] av, bv, mask, es;
        logic        ci, sb, ec;
        int          w, diff, total;
        w    = (sel != 0) ? 1 : 8;
        mask = (sel != 0) ? 32'h1 : 32'hFF;
        av   = $urandom & mask;
        bv   = $urandom & mask;
        ci   = 1'($urandom_range(0, 1));
`ifdef SERIAL_ADDER_SUB_EN
        sb   = 1'($urandom_range(0, 1));
`else
        sb   = 1'b0;
`endif
        if (sb) begin
          diff = int'(av) - int'(bv) - int'(ci);
          es   = 32'(diff) & mask;
          ec   = (diff >= 0);
        end else begin
          total = int'(av) + int'(bv) + int'(ci);
          es    = 32'(total) & mask;
          ec    = ((total >> w) & 1) != 0;
        end
        exp_q.push_back({ec, es});
        run_op(sel, av, bv, ci, sb, s, c);
        check((sel != 0) ? "sweep_w1" : "sweep_w8", {c, s}, exp_q.pop_front());
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
